// File: rtl/rob_param_pkg.sv
// Shared opcode-class constants and reorder-buffer defaults for the retirement queue.
package rob_param_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] S_TYPE = 7'b0100011;

  localparam int ROB_SIZE_WIDTH = 3;

  // Types whose result is known at issue and need no writeback.
  function automatic logic imm_ready(input logic [6:0] t);
    return (t == LUI) || (t == AUIPC) || (t == JAL);
  endfunction

endpackage

// File: rtl/rob_param_lookup.sv
// Operand lookup: same-cycle writeback bypass (lowest port first), else stored ready value.
module rob_lookup #(
  parameter int DEPTH_W  = 3,
  parameter int WB_PORTS = 2
) (
  input  logic [DEPTH_W-1:0]          q_id,
  input  logic [WB_PORTS-1:0]         wb_valid,
  input  logic [WB_PORTS*DEPTH_W-1:0] wb_rob_id,
  input  logic [WB_PORTS*32-1:0]      wb_value,
  input  logic                        stored_ready,
  input  logic [31:0]                 stored_value,
  output logic                        q_ready,
  output logic [31:0]                 q_value
);

  always_comb begin
    q_ready = stored_ready;
    q_value = stored_ready ? stored_value : 32'd0;
    // Walk from the highest port down so the lowest-index match lands last.
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (wb_valid[p] && (wb_rob_id[p*DEPTH_W +: DEPTH_W] == q_id)) begin
        q_ready = 1'b1;
        q_value = wb_value[p*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order retirement, multi-port writeback, commit-time
// misprediction recovery for branches and JALR.
module rob_param
  import rob_param_pkg::*;
#(
  parameter int DEPTH_W  = ROB_SIZE_WIDTH,
  parameter int WB_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [6:0]                  issue_type,
  input  logic [4:0]                  issue_rd,
  input  logic [31:0]                 issue_pc,
  input  logic [31:0]                 issue_imm,
  input  logic                        issue_pred_taken,
  input  logic [31:0]                 issue_pred_target,
  output logic [DEPTH_W-1:0]          issue_rob_id,
  input  logic [WB_PORTS-1:0]         wb_valid,
  input  logic [WB_PORTS*DEPTH_W-1:0] wb_rob_id,
  input  logic [WB_PORTS*32-1:0]      wb_value,
  input  logic [WB_PORTS-1:0]         wb_taken,
  input  logic [WB_PORTS*32-1:0]      wb_target,
  input  logic [DEPTH_W-1:0]          q_id1,
  input  logic [DEPTH_W-1:0]          q_id2,
  output logic                        q_ready1,
  output logic                        q_ready2,
  output logic [31:0]                 q_value1,
  output logic [31:0]                 q_value2,
  output logic                        commit_valid,
  output logic [DEPTH_W-1:0]          commit_rob_id,
  output logic [4:0]                  commit_rd,
  output logic [31:0]                 commit_value,
  output logic [DEPTH_W-1:0]          head_rob_id,
  output logic [DEPTH_W:0]            count,
  output logic                        flush,
  output logic [31:0]                 flush_pc
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [DEPTH-1:0]   busy, ready, pred_taken_q, taken_q;
  logic [6:0]         type_q        [DEPTH];
  logic [4:0]         rd_q          [DEPTH];
  logic [31:0]        pc_q          [DEPTH];
  logic [31:0]        value_q       [DEPTH];
  logic [31:0]        pred_target_q [DEPTH];
  logic [31:0]        target_q      [DEPTH];
  logic [DEPTH_W-1:0] head, tail;

  logic [DEPTH_W-1:0] wb_id [WB_PORTS];
  logic [WB_PORTS-1:0] wb_fire;
  logic        issue_fire, head_branch, head_jalr, head_store, mispredict;
  logic [31:0] issue_value;

  assign issue_ready   = (count != (DEPTH_W+1)'(DEPTH));
  assign issue_rob_id  = tail;
  assign head_rob_id   = head;
  assign commit_rob_id = head;
  assign commit_valid  = rdy && busy[head] && ready[head];

  assign head_branch = (type_q[head] == B_TYPE);
  assign head_jalr   = (type_q[head] == JALR);
  assign head_store  = (type_q[head] == S_TYPE);

  always_comb begin
    mispredict = 1'b0;
    if (head_branch)
      mispredict = (taken_q[head] != pred_taken_q[head]) ||
                   (taken_q[head] && (target_q[head] != pred_target_q[head]));
    else if (head_jalr)
      mispredict = (target_q[head] != pred_target_q[head]);
  end

  assign flush = commit_valid && mispredict;

  always_comb begin
    flush_pc = 32'd0;
    if (flush) begin
      if (head_branch && !taken_q[head]) flush_pc = pc_q[head] + 32'd4;
      else                               flush_pc = target_q[head];
    end
  end

  assign commit_rd    = (commit_valid && !head_branch && !head_store) ? rd_q[head] : 5'd0;
  assign commit_value = commit_valid ? value_q[head] : 32'd0;

  assign issue_fire = issue_valid && issue_ready && rdy && !flush;

  always_comb begin
    unique case (issue_type)
      LUI:     issue_value = issue_imm;
      AUIPC:   issue_value = issue_pc + issue_imm;
      JAL:     issue_value = issue_pc + 32'd4;
      default: issue_value = 32'd0;
    endcase
  end

  // Writebacks aimed at free entries are dropped; a flush also drops them.
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_id[p]   = wb_rob_id[p*DEPTH_W +: DEPTH_W];
      wb_fire[p] = rdy && !flush && wb_valid[p] && busy[wb_id[p]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        for (int p = 0; p < WB_PORTS; p++)
          if (wb_fire[p]) ready[wb_id[p]] <= 1'b1;
        if (issue_fire) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= imm_ready(issue_type);
          tail        <= tail + 1'b1;
        end
        if (commit_valid) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + 1'b1;
        end
        count <= count + (DEPTH_W+1)'(issue_fire) - (DEPTH_W+1)'(commit_valid);
      end
    end
  end

  // Payload storage carries no reset; busy/ready qualify every read.
  always_ff @(posedge clk) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_fire[p]) begin
        value_q[wb_id[p]]  <= wb_value[p*32 +: 32];
        taken_q[wb_id[p]]  <= wb_taken[p];
        target_q[wb_id[p]] <= wb_target[p*32 +: 32];
      end
    end
    if (issue_fire) begin
      type_q[tail]        <= issue_type;
      rd_q[tail]          <= issue_rd;
      pc_q[tail]          <= issue_pc;
      value_q[tail]       <= issue_value;
      pred_taken_q[tail]  <= issue_pred_taken;
      pred_target_q[tail] <= issue_pred_target;
    end
  end

  rob_lookup #(.DEPTH_W(DEPTH_W), .WB_PORTS(WB_PORTS)) u_lookup1 (
    .q_id         (q_id1),
    .wb_valid     (wb_valid),
    .wb_rob_id    (wb_rob_id),
    .wb_value     (wb_value),
    .stored_ready (busy[q_id1] && ready[q_id1]),
    .stored_value (value_q[q_id1]),
    .q_ready      (q_ready1),
    .q_value      (q_value1)
  );

  rob_lookup #(.DEPTH_W(DEPTH_W), .WB_PORTS(WB_PORTS)) u_lookup2 (
    .q_id         (q_id2),
    .wb_valid     (wb_valid),
    .wb_rob_id    (wb_rob_id),
    .wb_value     (wb_value),
    .stored_ready (busy[q_id2] && ready[q_id2]),
    .stored_value (value_q[q_id2]),
    .q_ready      (q_ready2),
    .q_value      (q_value2)
  );

endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: expected commits queued at issue, checked at retirement.
module tb_rob_param;
  import rob_param_pkg::*;

  localparam int DW = 3;
  localparam int DEPTH = 8;
  localparam logic [6:0] ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst, rdy, issue_valid, issue_ready, issue_pred_taken;
  logic [6:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc, issue_imm, issue_pred_target;
  logic [DW-1:0] issue_rob_id, q_id1, q_id2, commit_rob_id, head_rob_id;
  logic [1:0]  wb_valid, wb_taken;
  logic [2*DW-1:0] wb_rob_id;
  logic [63:0] wb_value, wb_target;
  logic        q_ready1, q_ready2, commit_valid, flush;
  logic [31:0] q_value1, q_value2, commit_value, flush_pc;
  logic [4:0]  commit_rd;
  logic [DW:0] count;

  rob_param #(.DEPTH_W(DW), .WB_PORTS(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
    .issue_rd(issue_rd), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_pred_taken(issue_pred_taken), .issue_pred_target(issue_pred_target),
    .issue_rob_id(issue_rob_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .wb_taken(wb_taken), .wb_target(wb_target),
    .q_id1(q_id1), .q_id2(q_id2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_value1(q_value1), .q_value2(q_value2),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
    .commit_value(commit_value), .head_rob_id(head_rob_id), .count(count),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] id;
    logic [4:0]    rd;
    logic [31:0]   val;
    logic          fl;
    logic [31:0]   fpc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_err = 0;
  int mcount = 0, mtail = 0;
  logic [4:0]  pend_rd;
  logic [31:0] pend_val, pend_fpc;
  logic        pend_fl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Retirement monitor and issue-acceptance model, sampled mid-cycle.
  exp_t e;
  logic popped, fl_now, acc;
  always @(negedge clk) begin
    if (!rst) begin
      popped = 1'b0;
      fl_now = 1'b0;
      if (commit_valid) begin
        if (sb.size() == 0) chk("unexpected_commit", 1, 0);
        else begin
          e = sb.pop_front();
          popped = 1'b1;
          fl_now = e.fl;
          chk("commit_id", commit_rob_id, e.id);
          chk("commit_rd", commit_rd, e.rd);
          chk("commit_value", commit_value, e.val);
          chk("flush", flush, e.fl);
          chk("flush_pc", flush_pc, e.fl ? e.fpc : 32'd0);
        end
      end else begin
        chk("flush_idle", flush, 0);
      end
      if (issue_valid) begin
        chk("issue_ready", issue_ready, mcount < DEPTH);
        chk("issue_rob_id", issue_rob_id, 64'(mtail));
      end
      acc = issue_valid && rdy && (mcount < DEPTH) && !fl_now;
      if (fl_now) begin
        sb.delete();
        mcount = 0;
        mtail  = 0;
      end else begin
        if (acc) begin
          sb.push_back('{id: DW'(mtail), rd: pend_rd, val: pend_val, fl: pend_fl, fpc: pend_fpc});
          mtail = (mtail + 1) % DEPTH;
        end
        mcount = mcount + int'(acc) - int'(popped);
      end
    end
  end

  task automatic do_issue(input logic [6:0] t, input logic [4:0] rd, input logic [31:0] pc,
                          input logic [31:0] imm, input logic pt, input logic [31:0] ptgt,
                          input logic [31:0] ev, input logic ef, input logic [31:0] efpc);
    issue_type = t; issue_rd = rd; issue_pc = pc; issue_imm = imm;
    issue_pred_taken = pt; issue_pred_target = ptgt;
    pend_rd  = (t == B_TYPE || t == S_TYPE) ? 5'd0 : rd;
    pend_val = ev; pend_fl = ef; pend_fpc = efpc;
    issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [1:0] v,
                       input logic [DW-1:0] i0, input logic [31:0] v0, input logic t0, input logic [31:0] g0,
                       input logic [DW-1:0] i1, input logic [31:0] v1, input logic t1, input logic [31:0] g1);
    wb_valid = v; wb_rob_id = {i1, i0}; wb_value = {v1, v0};
    wb_taken = {t1, t0}; wb_target = {g1, g0};
    @(posedge clk); #1;
    wb_valid = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0; issue_type = ALU; issue_rd = '0;
    issue_pc = '0; issue_imm = '0; issue_pred_taken = 1'b0; issue_pred_target = '0;
    wb_valid = '0; wb_rob_id = '0; wb_value = '0; wb_taken = '0; wb_target = '0;
    q_id1 = '0; q_id2 = '0;
    pend_rd = '0; pend_val = '0; pend_fl = 1'b0; pend_fpc = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_issue_id", issue_rob_id, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_rd", commit_rd, 0);
    chk("rst_commit_value", commit_value, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_count", count, 0);
    chk("rst_q_ready1", q_ready1, 0);
    chk("rst_q_ready2", q_ready2, 0);
    rst = 1'b0;

    // Immediately-ready types
    do_issue(LUI,   5, 32'h0,    32'h1234, 0, 0, 32'h1234, 0, 0);
    do_issue(AUIPC, 6, 32'h1000, 32'h20,   0, 0, 32'h1020, 0, 0);
    do_issue(JAL,   1, 32'h2000, 32'h0,    0, 0, 32'h2004, 0, 0);
    idle(2);
    chk("imm_drain_count", count, 0);

    // Fill to full (ids 3..7,0,1,2), then a refused ninth issue
    for (int k = 0; k < 8; k++) do_issue(ALU, 5'(k + 1), 32'h0, 32'h0, 0, 0, 32'h100 + k, 0, 0);
    chk("full_count", count, 8);
    chk("full_issue_ready", issue_ready, 0);
    do_issue(ALU, 9, 0, 0, 0, 0, 32'hDEAD, 0, 0);
    chk("full_refused_count", count, 8);
    for (int k = 7; k >= 1; k--)
      do_wb(2'b01, DW'((3 + k) % 8), 32'h100 + k, 0, 0, '0, 0, 0, 0);
    chk("no_early_commit", commit_valid, 0);
    do_wb(2'b01, 3'd3, 32'h100, 0, 0, '0, 0, 0, 0);
    @(posedge clk); #1;
    chk("ready_after_commit", issue_ready, 1);
    idle(8);
    chk("reorder_drain_count", count, 0);

    // Branch predicted not-taken, actually taken; younger op and same-cycle issue dropped
    do_issue(B_TYPE, 9, 32'h100, 0, 0, 32'h0, 32'h55, 1, 32'h200);
    do_issue(ALU, 2, 0, 0, 0, 0, 32'h0, 0, 0);
    do_wb(2'b01, 3'd3, 32'h55, 1, 32'h200, '0, 0, 0, 0);
    do_issue(ALU, 3, 0, 0, 0, 0, 32'h0, 0, 0);
    chk("flush_count", count, 0);
    chk("flush_tail", issue_rob_id, 0);

    // Predicted taken, actually not taken
    do_issue(B_TYPE, 0, 32'h40, 0, 1, 32'h80, 32'h0, 1, 32'h44);
    do_wb(2'b01, 3'd0, 32'h0, 0, 32'h80, '0, 0, 0, 0);
    idle(1);
    chk("nt_flush_count", count, 0);
    // Correctly predicted branch and JALR, then mispredicted JALR
    do_issue(B_TYPE, 0, 32'h60, 0, 1, 32'h90, 32'h0, 0, 0);
    do_wb(2'b01, 3'd0, 32'h0, 1, 32'h90, '0, 0, 0, 0);
    idle(1);
    do_issue(JALR, 1, 32'h70, 0, 1, 32'h300, 32'h74, 0, 0);
    do_wb(2'b01, 3'd1, 32'h74, 1, 32'h300, '0, 0, 0, 0);
    idle(1);
    do_issue(JALR, 1, 32'h74, 0, 1, 32'h300, 32'h78, 1, 32'h304);
    do_wb(2'b01, 3'd2, 32'h78, 1, 32'h304, '0, 0, 0, 0);
    idle(1);
    chk("jalr_flush_count", count, 0);

    // Dual-port collision, bypass lookup, rdy freeze
    do_issue(ALU, 10, 0, 0, 0, 0, 32'h10, 0, 0);
    do_issue(ALU, 11, 0, 0, 0, 0, 32'h11, 0, 0);
    do_issue(ALU, 12, 0, 0, 0, 0, 32'h12, 0, 0);
    do_issue(ALU, 13, 0, 0, 0, 0, 32'hBB, 0, 0);
    q_id1 = 3'd3; q_id2 = 3'd0;
    wb_valid = 2'b11; wb_rob_id = {3'd3, 3'd3}; wb_value = {32'hBB, 32'hAA};
    wb_taken = '0; wb_target = '0;
    #2;
    chk("bypass_ready1", q_ready1, 1);
    chk("bypass_value1", q_value1, 32'hAA);
    chk("unready_q2", q_ready2, 0);
    chk("unready_v2", q_value2, 0);
    @(posedge clk); #1;
    wb_valid = 2'b00;
    #2;
    chk("stored_ready1", q_ready1, 1);
    chk("stored_value1", q_value1, 32'hBB);
    @(posedge clk); #1;
    rdy = 1'b0;
    wb_valid = 2'b01; wb_rob_id = {3'd0, 3'd0}; wb_value = {32'h0, 32'h77};
    issue_type = ALU; issue_valid = 1'b1;
    pend_rd = 5'd20; pend_val = 32'h0; pend_fl = 1'b0; pend_fpc = 32'h0;
    #1;
    chk("frozen_commit_valid", commit_valid, 0);
    repeat (2) @(posedge clk); #1;
    rdy = 1'b1; wb_valid = 2'b00; issue_valid = 1'b0;
    #1;
    chk("frozen_count", count, 4);
    chk("frozen_tail", issue_rob_id, 4);
    chk("frozen_wb_ignored", q_ready2, 0);
    @(posedge clk); #1;
    do_wb(2'b11, 3'd0, 32'h10, 0, 0, 3'd1, 32'h11, 0, 0);
    do_wb(2'b01, 3'd2, 32'h12, 0, 0, '0, 0, 0, 0);
    idle(5);
    chk("dual_drain_count", count, 0);
    chk("sb_drain", sb.size(), 0);

    // Asynchronous reset mid-operation
    do_issue(ALU, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    do_issue(ALU, 2, 0, 0, 0, 0, 32'h0, 0, 0);
    chk("pre_async_count", count, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_tail", issue_rob_id, 0);
    chk("async_issue_ready", issue_ready, 1);
    sb.delete();
    mcount = 0;
    mtail = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
